// File: rtl/gvp_stream_packer.sv
// Purpose : frames each GVP store trigger (store type, source mask, index, time, selected sources) into an AXI4-Stream word sequence.
// Latency : trigger in cycle T -> first word (w0) valid in T+1; one word per accepted beat thereafter.
// Backpr. : holds tdata/tlast/tvalid stable while tready=0; drives stall high for the whole frame; triggers while busy are dropped and counted.
//
// Ports:
//   a_clk, reset          clock, asynchronous active-high reset
//   store_data[1:0]       GVP store trigger (0 none, 1 data point, 2 vector header, 3 end mark)
//   options[31:0]         section options; source mask at options[SRCS_LSB +: NUM_SRCS]
//   index[31:0]           GVP point index
//   gvp_time[47:0]        GVP time counter
//   src_data              NUM_SRCS x 32-bit source channels, channel k at [k*32 +: 32]
//   M_AXIS_*              AXI4-Stream master (tdata, tvalid, tlast, tready)
//   stall                 busy / back-pressure to the GVP
//   overrun_count[15:0]   saturating count of triggers dropped while busy
module gvp_stream_packer #(
  parameter int NUM_SRCS = 16,
  parameter int SRCS_LSB = 0
) (
  input  logic                     a_clk,
  input  logic                     reset,
  input  logic [1:0]               store_data,
  input  logic [31:0]              options,
  input  logic [31:0]              index,
  input  logic [47:0]              gvp_time,
  input  logic [NUM_SRCS*32-1:0]   src_data,
  output logic [31:0]              M_AXIS_tdata,
  output logic                     M_AXIS_tvalid,
  output logic                     M_AXIS_tlast,
  input  logic                     M_AXIS_tready,
  output logic                     stall,
  output logic [15:0]              overrun_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_TIME = 2'd2;
  localparam logic [1:0] S_SRC  = 2'd3;

  logic [1:0]             state_q,    state_d;
  logic                   sub_q,      sub_d;       // word select inside HDR/TIME
  logic [1:0]             store_q,    store_d;
  logic [31:0]            index_q,    index_d;
  logic [1:0]             st_q,       st_d;
  logic [NUM_SRCS-1:0]    mask_q,     mask_d;
  logic [NUM_SRCS-1:0]    work_q,     work_d;      // sources still to be sent
  logic [31:0]            idx_snap_q, idx_snap_d;
  logic [47:0]            time_snap_q, time_snap_d;
  logic [NUM_SRCS*32-1:0] src_snap_q, src_snap_d;
  logic [15:0]            ovr_q,      ovr_d;

  logic [NUM_SRCS-1:0]    mask_in;
  logic                   trig;
  logic                   busy;
  logic                   accept;
  logic [NUM_SRCS-1:0]    low_bit;
  logic [NUM_SRCS-1:0]    work_rest;
  logic [31:0]            src_word;
  logic [7:0]             pop;
  logic [15:0]            mask16;
  logic                   last;

  assign mask_in = options[SRCS_LSB +: NUM_SRCS];

  // A store value held across paused/decimated GVP cycles fires only once:
  // a new trigger needs a change of store type or of index.
  assign trig   = (store_data != 2'd0) && ((store_data != store_q) || (index != index_q));
  assign busy   = (state_q != S_IDLE);
  assign accept = busy && M_AXIS_tready;

  // Lowest set bit of the working mask selects the next source word.
  // Scanning high to low lets the lowest set bit win.
  always_comb begin
    low_bit  = '0;
    src_word = '0;
    for (int k = NUM_SRCS - 1; k >= 0; k--) begin
      if (work_q[k]) begin
        low_bit    = '0;
        low_bit[k] = 1'b1;
        src_word   = src_snap_q[k*32 +: 32];
      end
    end
  end

  assign work_rest = work_q & ~low_bit;

  always_comb begin
    pop = '0;
    for (int k = 0; k < NUM_SRCS; k++) begin
      pop = pop + {7'd0, mask_q[k]};
    end
  end

  always_comb begin
    mask16                 = '0;
    mask16[NUM_SRCS-1:0]   = mask_q;
  end

  always_comb begin
    last = 1'b0;
    case (state_q)
      S_HDR:   last = sub_q && (st_q == 2'd1) && (work_q == '0);
      S_TIME:  last = sub_q && ((st_q == 2'd3) || (work_q == '0));
      S_SRC:   last = (work_rest == '0);
      default: last = 1'b0;
    endcase
  end

  always_comb begin
    M_AXIS_tdata = '0;
    case (state_q)
      S_HDR:   M_AXIS_tdata = sub_q ? idx_snap_q : {st_q, 6'b0, pop, mask16};
      S_TIME:  M_AXIS_tdata = sub_q ? {16'h0, time_snap_q[47:32]} : time_snap_q[31:0];
      S_SRC:   M_AXIS_tdata = src_word;
      default: M_AXIS_tdata = '0;
    endcase
  end

  assign M_AXIS_tvalid = busy;
  assign M_AXIS_tlast  = busy && last;
  assign stall         = busy;
  assign overrun_count = ovr_q;

  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    store_d     = store_data;
    index_d     = index;
    st_d        = st_q;
    mask_d      = mask_q;
    work_d      = work_q;
    idx_snap_d  = idx_snap_q;
    time_snap_d = time_snap_q;
    src_snap_d  = src_snap_q;
    ovr_d       = ovr_q;

    // Triggers are never queued; the cycle of the tlast accept is still busy.
    if (trig && busy && (ovr_q != 16'hFFFF)) begin
      ovr_d = ovr_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          st_d        = store_data;
          mask_d      = mask_in;
          work_d      = mask_in;
          idx_snap_d  = index;
          time_snap_d = gvp_time;
          src_snap_d  = src_data;
          sub_d       = 1'b0;
          state_d     = S_HDR;
        end
      end
      S_HDR: begin
        if (accept) begin
          if (!sub_q) begin
            sub_d = 1'b1;
          end else begin
            sub_d = 1'b0;
            if (st_q[1])             state_d = S_TIME;
            else if (work_q != '0)   state_d = S_SRC;
            else                     state_d = S_IDLE;
          end
        end
      end
      S_TIME: begin
        if (accept) begin
          if (!sub_q) begin
            sub_d = 1'b1;
          end else begin
            sub_d   = 1'b0;
            state_d = ((st_q != 2'd3) && (work_q != '0)) ? S_SRC : S_IDLE;
          end
        end
      end
      default: begin // S_SRC
        if (accept) begin
          work_d = work_rest;
          if (work_rest == '0) state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sub_q       <= 1'b0;
      store_q     <= '0;
      index_q     <= '0;
      st_q        <= '0;
      mask_q      <= '0;
      work_q      <= '0;
      idx_snap_q  <= '0;
      time_snap_q <= '0;
      src_snap_q  <= '0;
      ovr_q       <= '0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      store_q     <= store_d;
      index_q     <= index_d;
      st_q        <= st_d;
      mask_q      <= mask_d;
      work_q      <= work_d;
      idx_snap_q  <= idx_snap_d;
      time_snap_q <= time_snap_d;
      src_snap_q  <= src_snap_d;
      ovr_q       <= ovr_d;
    end
  end

endmodule
